// File: rtl/conv_window_gen.sv
// conv_window_gen: front end for the 3x3 convolution MAC.
//   Collects a serial 9-beat weight load into a shadow set and publishes it
//   atomically. It turns a raster-order pixel stream into 3x3 windows using
//   two line buffers and a 3x3 shift window (valid convolution, no padding).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   w_load, w_in         weight beat valid / data (beat n -> Weight_n)
//   pix_valid, pix_in    pixel stream, raster order
//   pix_ready            pixel accepted when pix_valid & pix_ready
//   in_valid, IFM_1..9   window valid / window (IFM_1 top-left, IFM_9 newest)
//   weight_valid         complete weight set on Weight_1..9
//   Weight_1..9          current weight set
//   frame_done           pulse alongside the last window of a frame
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w_load,
  input  logic [7:0] w_in,
  input  logic       pix_valid,
  input  logic [7:0] pix_in,
  output logic       pix_ready,
  output logic       in_valid,
  output logic [7:0] IFM_1,
  output logic [7:0] IFM_2,
  output logic [7:0] IFM_3,
  output logic [7:0] IFM_4,
  output logic [7:0] IFM_5,
  output logic [7:0] IFM_6,
  output logic [7:0] IFM_7,
  output logic [7:0] IFM_8,
  output logic [7:0] IFM_9,
  output logic       weight_valid,
  output logic [7:0] Weight_1,
  output logic [7:0] Weight_2,
  output logic [7:0] Weight_3,
  output logic [7:0] Weight_4,
  output logic [7:0] Weight_5,
  output logic [7:0] Weight_6,
  output logic [7:0] Weight_7,
  output logic [7:0] Weight_8,
  output logic [7:0] Weight_9,
  output logic       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_W_LOAD = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]             state;
  logic [3:0]             wcnt;
  // Only beats 1..8 need a shadow slot; beat 9 goes straight to w_cur.
  logic [7:0][7:0]        w_shadow;
  logic [8:0][7:0]        w_cur;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [IMG_W-1:0][7:0]  lb_old;   // row r-2 at column c
  logic [IMG_W-1:0][7:0]  lb_new;   // row r-1 at column c
  logic [2:0][2:0][7:0]   win;      // win[row][col], [2][2] is newest
  logic                   accept;
  logic                   col_last;
  logic                   row_last;

  assign pix_ready = (state == S_READY) || (state == S_STREAM);
  assign accept    = pix_valid & pix_ready;
  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wcnt         <= '0;
      w_shadow     <= '0;
      w_cur        <= '0;
      weight_valid <= 1'b0;
      col          <= '0;
      row          <= '0;
      lb_old       <= '0;
      lb_new       <= '0;
      win          <= '0;
      in_valid     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      in_valid   <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (w_load) begin
            w_shadow[0] <= w_in;
            wcnt        <= 4'd1;
            state       <= S_W_LOAD;
          end
        end
        S_W_LOAD: begin
          if (w_load) begin
            if (wcnt == 4'd8) begin
              // Publish the whole set at once so no partial set is visible.
              w_cur        <= {w_in, w_shadow};
              weight_valid <= 1'b1;
              wcnt         <= '0;
              state        <= S_READY;
            end else begin
              w_shadow[wcnt[2:0]] <= w_in;
              wcnt                <= wcnt + 4'd1;
            end
          end
        end
        S_READY: begin
          // A pixel in the same cycle as w_load takes priority.
          if (accept) begin
            state <= S_STREAM;
          end else if (w_load) begin
            w_shadow[0] <= w_in;
            wcnt        <= 4'd1;
            state       <= S_W_LOAD;
          end
        end
        S_STREAM: begin
          if (accept && col_last && row_last) state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2]   <= lb_old[col];
        win[1][2]   <= lb_new[col];
        win[2][2]   <= pix_in;
        lb_old[col] <= lb_new[col];
        lb_new[col] <= pix_in;

        // Columns 0/1 only prime the window, so no window crosses a row wrap.
        in_valid   <= (row >= RW'(2)) && (col >= CW'(2));
        frame_done <= col_last && row_last;

        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  assign IFM_1 = win[0][0];
  assign IFM_2 = win[0][1];
  assign IFM_3 = win[0][2];
  assign IFM_4 = win[1][0];
  assign IFM_5 = win[1][1];
  assign IFM_6 = win[1][2];
  assign IFM_7 = win[2][0];
  assign IFM_8 = win[2][1];
  assign IFM_9 = win[2][2];

  assign Weight_1 = w_cur[0];
  assign Weight_2 = w_cur[1];
  assign Weight_3 = w_cur[2];
  assign Weight_4 = w_cur[3];
  assign Weight_5 = w_cur[4];
  assign Weight_6 = w_cur[5];
  assign Weight_7 = w_cur[6];
  assign Weight_8 = w_cur[7];
  assign Weight_9 = w_cur[8];

endmodule
